// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request strobes, hopper acks, solenoid drives and status of the change dispenser.
interface change_dispenser_if #(parameter int CNT_W = 3);
    logic [2:0]       change;
    logic             product;
    logic             vend_ack;
    logic             dime_ack;
    logic             nickel_ack;
    logic             vend_fire;
    logic             dime_fire;
    logic             nickel_fire;
    logic             busy;
    logic             fault;
    logic             err;
    logic [CNT_W-1:0] pend_dimes;
    logic [CNT_W-1:0] pend_nickels;
    modport master (
        output change, product, vend_ack, dime_ack, nickel_ack,
        input  vend_fire, dime_fire, nickel_fire, busy, fault, err, pend_dimes, pend_nickels
    );
    modport slave (
        input  change, product, vend_ack, dime_ack, nickel_ack,
        output vend_fire, dime_fire, nickel_fire, busy, fault, err, pend_dimes, pend_nickels
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: queues product/change requests and fires the product, dime and nickel
// solenoids one at a time, waiting for each hopper ack with a timeout that latches a fault.
module change_dispenser #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 3
) (
    input logic clk,
    input logic reset,
    change_dispenser_if.slave bus
);
    localparam int TMAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, FAULT} state_t;
    typedef enum logic [1:0] {SEL_V, SEL_D, SEL_N} sel_t;

    state_t           state;
    sel_t             sel;
    logic [TW-1:0]    timer;
    logic [1:0]       vend_pend;
    logic [CNT_W-1:0] dimes, nickels;
    logic             vend_fire, dime_fire, nickel_fire, fault, err;
    logic             add_n, bad, done, dec_v, dec_d, dec_n;
    logic [1:0]       add_d;
    logic [2:0]       sum_v;
    logic [CNT_W:0]   sum_d, sum_n;

    always_comb begin
        add_n = (bus.change == 3'd1) || (bus.change == 3'd3) || (bus.change == 3'd5);
        add_d = (bus.change == 3'd2 || bus.change == 3'd3) ? 2'd1 :
                (bus.change == 3'd4 || bus.change == 3'd5) ? 2'd2 : 2'd0;
        bad   = bus.change[2] & bus.change[1];
        dec_v = state == WAIT_ACK && sel == SEL_V && bus.vend_ack;
        dec_d = state == WAIT_ACK && sel == SEL_D && bus.dime_ack;
        dec_n = state == WAIT_ACK && sel == SEL_N && bus.nickel_ack;
        done  = dec_v | dec_d | dec_n;
        // Max add is 2 onto an all-ones count, so the carry bit alone flags overflow.
        sum_v = {1'b0, vend_pend} + {2'b0, bus.product} - {2'b0, dec_v};
        sum_d = {1'b0, dimes} + (CNT_W+1)'(add_d) - (CNT_W+1)'(dec_d);
        sum_n = {1'b0, nickels} + (CNT_W+1)'(add_n) - (CNT_W+1)'(dec_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= SEL_V;
            timer       <= '0;
            vend_pend   <= '0;
            dimes       <= '0;
            nickels     <= '0;
            vend_fire   <= 1'b0;
            dime_fire   <= 1'b0;
            nickel_fire <= 1'b0;
            fault       <= 1'b0;
            err         <= 1'b0;
        end else begin
            vend_pend <= sum_v[2] ? 2'd3 : sum_v[1:0];
            dimes     <= sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
            nickels   <= sum_n[CNT_W] ? '1 : sum_n[CNT_W-1:0];
            if (bad | sum_v[2] | sum_d[CNT_W] | sum_n[CNT_W])
                err <= 1'b1;
            case (state)
                IDLE: begin
                    timer <= TW'(1);
                    if (vend_pend != 0) begin
                        sel       <= SEL_V;
                        vend_fire <= 1'b1;
                        state     <= FIRE;
                    end else if (dimes != 0) begin
                        sel       <= SEL_D;
                        dime_fire <= 1'b1;
                        state     <= FIRE;
                    end else if (nickels != 0) begin
                        sel         <= SEL_N;
                        nickel_fire <= 1'b1;
                        state       <= FIRE;
                    end
                end
                FIRE: begin
                    if (timer == TW'(PULSE_CYCLES)) begin
                        vend_fire   <= 1'b0;
                        dime_fire   <= 1'b0;
                        nickel_fire <= 1'b0;
                        timer       <= TW'(1);
                        state       <= WAIT_ACK;
                    end else
                        timer <= timer + 1'b1;
                end
                WAIT_ACK: begin
                    if (done)
                        state <= IDLE;
                    else if (timer == TW'(TIMEOUT_CYCLES)) begin
                        fault <= 1'b1;
                        state <= FAULT;
                    end else
                        timer <= timer + 1'b1;
                end
                default: state <= FAULT;
            endcase
        end
    end

    assign bus.vend_fire    = vend_fire;
    assign bus.dime_fire    = dime_fire;
    assign bus.nickel_fire  = nickel_fire;
    assign bus.fault        = fault;
    assign bus.err          = err;
    assign bus.pend_dimes   = dimes;
    assign bus.pend_nickels = nickels;
    assign bus.busy         = state != IDLE || vend_pend != 0 || dimes != 0 || nickels != 0;
endmodule
